// File: rtl/data_mem_resp_pkg.sv
// Shared types for the data memory responder: access sizes,
// FSM states and the 4-byte response lane bundle.
package data_mem_resp_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'd0,
        SZ_H  = 3'd1,
        SZ_W  = 3'd2,
        SZ_BU = 3'd4,
        SZ_HU = 3'd5
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef logic [3:0][7:0] byte_arr4_t;

    // Access width in bytes; 0 marks an illegal size code.
    function automatic logic [2:0] acc_width(input logic [2:0] size);
        case (size)
            SZ_B, SZ_BU: return 3'd1;
            SZ_H, SZ_HU: return 3'd2;
            SZ_W:        return 3'd4;
            default:     return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] width);
        case (width)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd4:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_resp_byte_ram.sv
// Byte-wide storage: 4-lane write enable at addr+0..3 and a
// combinational 4-lane read; lanes past the top read as zero.
// Ports: clk, addr, we[3:0], wdata, rdata.
module byte_ram
    import data_mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_BYTES)-1:0] addr,
    input  logic [3:0]                     we,
    input  byte_arr4_t                     wdata,
    output byte_arr4_t                     rdata
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);

    logic [7:0] mem [DEPTH_BYTES];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr + AW'(i)] <= wdata[i];
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_rd
        logic [AW:0] idx;
        assign idx = {1'b0, addr} + (AW+1)'(i);
        assign rdata[i] = (idx < (AW+1)'(DEPTH_BYTES))
                        ? mem[idx[AW-1:0]] : 8'h00;
    end

endmodule

// File: rtl/data_mem_resp.sv
// Single-outstanding data memory with fixed wait latency.
// Ports: clk, rst_n, req_* handshake/fields, rsp_* handshake/data/err.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output byte_arr4_t  rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        wr_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        idle;
    logic        accept;
    logic        wr_e;
    logic [2:0]  size_e;
    logic [31:0] addr_e;
    logic [31:0] wdata_e;
    logic [2:0]  width;
    logic        illegal;
    logic        misalign;
    logic        range_err;
    logic        err;
    logic        enter_resp;
    logic [3:0]  we;
    byte_arr4_t  ram_rdata;

    assign idle   = (state_q == ST_IDLE);
    assign accept = req_valid & idle;

    // Live fields while idle: with no wait cycles the store
    // lands on the accepting edge itself.
    assign wr_e    = idle ? req_write : wr_q;
    assign size_e  = idle ? req_size  : size_q;
    assign addr_e  = idle ? req_addr  : addr_q;
    assign wdata_e = idle ? req_wdata : wdata_q;

    always_comb begin
        width     = acc_width(size_e);
        illegal   = (width == 3'd0) || (wr_e && size_e[2]);
        misalign  = ((width == 3'd2) && addr_e[0])
                 || ((width == 3'd4) && (addr_e[1:0] != 2'b00));
        // Full 32-bit compare so high address bits never wrap.
        range_err = ({1'b0, addr_e} + {30'd0, width})
                  > 33'(DEPTH_BYTES);
        err       = illegal | misalign | range_err;
    end

    assign enter_resp = idle
        ? (accept && (WAIT_CYCLES == 0))
        : ((state_q == ST_WAIT) && (cnt_q == 4'd1));

    assign we = (enter_resp && wr_e && !err)
              ? lane_mask(width) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                        cnt_q   <= 4'(WAIT_CYCLES);
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            wr_q    <= req_write;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    byte_ram #(
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_ram (
        .clk   (clk),
        .addr  (addr_e[AW-1:0]),
        .we    (we),
        .wdata (wdata_e),
        .rdata (ram_rdata)
    );

    // Storage is static during RESP, so the read is stable there.
    assign req_ready = idle;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid & err;
    assign rsp_rdata = (rsp_valid && !err) ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: vector table through a scoreboard,
// plus stall, reset-abort and zero-wait sequences.
module tb_data_mem_resp;
    import data_mem_resp_pkg::*;

    localparam int A_WAIT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    byte_arr4_t  rsp_rdata;

    logic        z_req_valid, z_req_ready;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    byte_arr4_t  z_rsp_rdata;

    data_mem_resp #(.DEPTH_BYTES(1024), .WAIT_CYCLES(A_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_resp #(.DEPTH_BYTES(1024), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_d;
        logic        exp_e;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic add(input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee,
                       input string nm);
        vec_t v;
        v.wr = wr; v.size = sz; v.addr = a; v.wdata = wd;
        v.exp_d = ed; v.exp_e = ee; v.name = nm;
        vecs.push_back(v);
    endtask

    // Scoreboard: compare on every response handshake.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_rsp: got data=%h err=%b",
                         rsp_rdata, rsp_err);
            end else begin
                e = sb.pop_front();
                if (rsp_rdata !== e.d || rsp_err !== e.e) begin
                    n_bad++;
                    $display("FAIL %s: got data=%h err=%b want data=%h err=%b",
                             e.name, rsp_rdata, rsp_err, e.d, e.e);
                end
            end
        end
    end

    // Call just after a rising edge; returns just after the
    // accepting edge with req_valid dropped.
    task automatic drive_req(input logic wr, input logic [2:0] sz,
                             input logic [31:0] a, input logic [31:0] wd);
        int t;
        req_valid = 1'b1; req_write = wr; req_size = sz;
        req_addr = a; req_wdata = wd;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: req_ready 0 want 1");
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic send(input vec_t v);
        exp_t e;
        int   lat;
        e.d = v.exp_d; e.e = v.exp_e; e.name = v.name;
        sb.push_back(e);
        drive_req(v.wr, v.size, v.addr, v.wdata);
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({v.name, "_latency"}, lat, A_WAIT + 1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; z_req_valid = 1'b0;
        rsp_ready = 1'b1; z_rsp_ready = 1'b1;
        req_write = 1'b0; req_size = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;

        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_z_rsp_valid", z_rsp_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        add(1, 3'd2, 32'h14, 32'h04030201, 32'h04030201, 0, "st_w_14");
        add(1, 3'd2, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 0, "st_w_10");
        add(0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 0, "ld_w_10");
        add(1, 3'd0, 32'h12, 32'hAABBCC55, 32'h0201DE55, 0, "st_b_12");
        add(0, 3'd2, 32'h10, 32'h0,        32'hDE55BEEF, 0, "ld_w_10b");
        add(0, 3'd1, 32'h11, 32'h0,        32'h00000000, 1, "ld_h_mis");
        add(1, 3'd2, 32'h3FC, 32'h89ABCDEF, 32'h89ABCDEF, 0, "st_w_3fc");
        add(1, 3'd2, 32'h3FE, 32'h12345678, 32'h00000000, 1, "st_w_3fe");
        add(0, 3'd2, 32'h3FC, 32'h0,       32'h89ABCDEF, 0, "ld_w_3fc");
        add(0, 3'd0, 32'h3FE, 32'h0,       32'h000089AB, 0, "ld_b_top");
        add(0, 3'd1, 32'h3FE, 32'h0,       32'h000089AB, 0, "ld_h_top");
        add(0, 3'd4, 32'h13, 32'h0,        32'h030201DE, 0, "ld_bu_13");
        add(0, 3'd5, 32'h12, 32'h0,        32'h0201DE55, 0, "ld_hu_12");
        add(1, 3'd4, 32'h10, 32'h0,        32'h00000000, 1, "st_bu_ill");
        add(0, 3'd3, 32'h10, 32'h0,        32'h00000000, 1, "ld_sz3");
        add(0, 3'd6, 32'h10, 32'h0,        32'h00000000, 1, "ld_sz6");
        add(0, 3'd2, 32'h12, 32'h0,        32'h00000000, 1, "ld_w_mis");
        add(0, 3'd2, 32'h400, 32'h0,       32'h00000000, 1, "ld_w_oor");
        add(0, 3'd2, 32'h10000010, 32'h0,  32'h00000000, 1, "ld_w_hi");
        add(1, 3'd1, 32'h14, 32'hFFFF7777, 32'h04037777, 0, "st_h_14");
        add(1, 3'd1, 32'h15, 32'h0000AAAA, 32'h00000000, 1, "st_h_mis");
        add(0, 3'd2, 32'h14, 32'h0,        32'h04037777, 0, "ld_w_14");
        add(1, 3'd2, 32'h20, 32'h0BADF00D, 32'h0BADF00D, 0, "st_w_20");

        foreach (vecs[i]) begin
            send(vecs[i]);
            @(posedge clk); #1;
        end

        // Response stall: outputs hold while rsp_ready is low.
        rsp_ready = 1'b0;
        begin
            vec_t v;
            v.wr = 0; v.size = 3'd2; v.addr = 32'h10; v.wdata = 0;
            v.exp_d = 32'hDE55BEEF; v.exp_e = 0; v.name = "stall_ld";
            send(v);
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rsp_rdata", rsp_rdata, 32'hDE55BEEF);
            chk("stall_req_ready", req_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_idle_ready", req_ready, 1);
        chk("stall_idle_valid", rsp_valid, 0);
        @(posedge clk); #1;

        // Reset one cycle after accepting a store aborts it.
        drive_req(1, 3'd2, 32'h20, 32'h11223344);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_req_ready", req_ready, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_err", rsp_err, 0);
        chk("abort_rsp_rdata", rsp_rdata, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        begin
            vec_t v;
            v.wr = 0; v.size = 3'd2; v.addr = 32'h20; v.wdata = 0;
            v.exp_d = 32'h0BADF00D; v.exp_e = 0; v.name = "abort_ld";
            send(v);
        end
        @(posedge clk); #1;

        // Zero-wait instance: response in the cycle after accept.
        req_write = 1'b1; req_size = 3'd2;
        req_addr = 32'h8; req_wdata = 32'hCAFEF00D;
        z_req_valid = 1'b1;
        @(negedge clk);
        chk("z_req_ready", z_req_ready, 1);
        @(posedge clk); #1 z_req_valid = 1'b0;
        @(negedge clk);
        chk("z_st_valid", z_rsp_valid, 1);
        chk("z_st_rdata", z_rsp_rdata, 32'hCAFEF00D);
        chk("z_st_err", z_rsp_err, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("z_idle_valid", z_rsp_valid, 0);
        chk("z_idle_ready", z_req_ready, 1);
        req_write = 1'b0;
        z_req_valid = 1'b1;
        @(posedge clk); #1 z_req_valid = 1'b0;
        @(negedge clk);
        chk("z_ld_valid", z_rsp_valid, 1);
        chk("z_ld_rdata", z_rsp_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;

        if (sb.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL sb_drain: %0d responses outstanding want 0",
                     sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
